// File: rtl/arbiter_pkg.sv
// Shared definitions for the weighted round-robin arbiter slice.
// Optional lock feature is enabled with WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN.
package arbiter_pkg;

  // Smallest burst a channel can own; a programmed weight of 0 is raised to this.
  localparam int unsigned MIN_WEIGHT = 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PENDING,
    SRC_OWNER,
    SRC_SEARCH
  } grant_src_e;

  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/static_priority_arbiter.sv
// Fixed-priority picker: the lowest-index asserted request wins.
// Used unchanged whether or not WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN is defined.
module static_priority_arbiter #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [SIZE-1:0]  requests,
  output logic [SIZE-1:0]  grant,
  output logic [IDX_W-1:0] grant_index,
  output logic             grant_valid
);

  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (requests[i] && !grant_valid) begin
        grant_valid = 1'b1;
        grant[i]    = 1'b1;
        grant_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wrr_credit_counter.sv
// Burst ownership tracker: owner, owner_active and remaining credits.
// With WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN, a locked transfer claims and holds ownership.
module wrr_credit_counter
  import arbiter_pkg::*;
#(
  parameter int unsigned SIZE         = 4,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter int unsigned IDX_W        = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    transfer,
  input  logic [IDX_W-1:0]        grant_index,
  input  logic [WEIGHT_WIDTH-1:0] grant_weight,
  input  logic                    pending,
  input  logic [SIZE-1:0]         requests,
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
  input  logic                    lock,
`endif
  output logic [IDX_W-1:0]        owner,
  output logic                    owner_active,
  output logic                    release_valid,
  output logic [IDX_W-1:0]        release_index
);

  logic [IDX_W-1:0]        owner_q, owner_d;
  logic                    owner_active_q, owner_active_d;
  logic [WEIGHT_WIDTH-1:0] credits_q, credits_d;
  logic [WEIGHT_WIDTH-1:0] burst;
  logic                    hold;

`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
  assign hold = lock;
`else
  assign hold = 1'b0;
`endif

  assign burst = (grant_weight < WEIGHT_WIDTH'(MIN_WEIGHT)) ? WEIGHT_WIDTH'(MIN_WEIGHT)
                                                            : grant_weight;

  always_comb begin
    owner_d        = owner_q;
    owner_active_d = owner_active_q;
    credits_d      = credits_q;
    release_valid  = 1'b0;
    release_index  = owner_q;
    if (transfer) begin
      if (owner_active_q && (grant_index == owner_q)) begin
        // credits==0 is only reachable after a locked load and counts as exhausted
        if (!hold) begin
          if (credits_q <= WEIGHT_WIDTH'(1)) begin
            owner_active_d = 1'b0;
            credits_d      = '0;
            release_valid  = 1'b1;
            release_index  = owner_q;
          end else begin
            credits_d = credits_q - WEIGHT_WIDTH'(1);
          end
        end
      end else if (hold || (burst > WEIGHT_WIDTH'(1))) begin
        owner_d        = grant_index;
        owner_active_d = 1'b1;
        credits_d      = burst - WEIGHT_WIDTH'(1);
      end else begin
        owner_active_d = 1'b0;
        release_valid  = 1'b1;
        release_index  = grant_index;
      end
    end else if (owner_active_q && !pending && !requests[owner_q]) begin
      owner_active_d = 1'b0;
      release_valid  = 1'b1;
      release_index  = owner_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q        <= '0;
      owner_active_q <= 1'b0;
      credits_q      <= '0;
    end else begin
      owner_q        <= owner_d;
      owner_active_q <= owner_active_d;
      credits_q      <= credits_d;
    end
  end

  assign owner        = owner_q;
  assign owner_active = owner_active_q;

endmodule

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: per-channel burst credit, round-robin hand-off, stall hold.
// Define WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN to add the lock input.
module weighted_round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned SIZE         = 4,
  parameter int unsigned WEIGHT_WIDTH = 4,
  localparam int unsigned IDX_W       = index_width(SIZE)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SIZE-1:0]              requests,
  input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
  input  logic                         ready,
  output logic [SIZE-1:0]              grant,
  output logic [IDX_W-1:0]             grant_index,
  output logic                         grant_valid
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
  ,
  input  logic                         lock
`endif
);

  logic [IDX_W-1:0]        pointer_q, pointer_d;
  logic                    pending_q, pending_d;
  logic [IDX_W-1:0]        pending_index_q, pending_index_d;

  logic [IDX_W-1:0]        owner;
  logic                    owner_active;
  logic                    release_valid;
  logic [IDX_W-1:0]        release_index;

  logic [SIZE-1:0]         masked_requests;
  logic [SIZE-1:0]         masked_grant, raw_grant;
  logic [IDX_W-1:0]        masked_index, raw_index;
  logic                    masked_valid, raw_valid;

  grant_src_e              grant_src;
  logic [IDX_W-1:0]        sel_index;
  logic [WEIGHT_WIDTH-1:0] grant_weight;
  logic                    transfer;

  function automatic logic [SIZE-1:0] onehot(input logic [IDX_W-1:0] idx);
    return SIZE'(1) << idx;
  endfunction

  always_comb begin
    masked_requests = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      masked_requests[i] = requests[i] && (i >= 32'(pointer_q));
    end
  end

  static_priority_arbiter #(.SIZE(SIZE), .IDX_W(IDX_W)) u_masked_search (
    .requests    (masked_requests),
    .grant       (masked_grant),
    .grant_index (masked_index),
    .grant_valid (masked_valid)
  );

  static_priority_arbiter #(.SIZE(SIZE), .IDX_W(IDX_W)) u_raw_search (
    .requests    (requests),
    .grant       (raw_grant),
    .grant_index (raw_index),
    .grant_valid (raw_valid)
  );

  // Priority: held stall grant, then the live burst owner, then the round-robin search.
  always_comb begin
    grant_src = SRC_NONE;
    sel_index = '0;
    if (pending_q) begin
      grant_src = SRC_PENDING;
      sel_index = pending_index_q;
    end else if (owner_active && requests[owner]) begin
      grant_src = SRC_OWNER;
      sel_index = owner;
    end else if (masked_valid) begin
      grant_src = SRC_SEARCH;
      sel_index = masked_index;
    end else if (raw_valid) begin
      grant_src = SRC_SEARCH;
      sel_index = raw_index;
    end
  end

  always_comb begin
    grant = '0;
    unique case (grant_src)
      SRC_PENDING: grant = onehot(pending_index_q);
      SRC_OWNER:   grant = onehot(owner);
      SRC_SEARCH:  grant = masked_valid ? masked_grant : raw_grant;
      default:     grant = '0;
    endcase
  end

  assign grant_valid = (grant_src != SRC_NONE);
  assign grant_index = sel_index;
  assign transfer    = grant_valid && ready;

  always_comb begin
    grant_weight = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (sel_index == IDX_W'(i)) begin
        grant_weight = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  wrr_credit_counter #(
    .SIZE         (SIZE),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .IDX_W        (IDX_W)
  ) u_credit (
    .clock         (clock),
    .reset         (reset),
    .transfer      (transfer),
    .grant_index   (sel_index),
    .grant_weight  (grant_weight),
    .pending       (pending_q),
    .requests      (requests),
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    .lock          (lock),
`endif
    .owner         (owner),
    .owner_active  (owner_active),
    .release_valid (release_valid),
    .release_index (release_index)
  );

  always_comb begin
    pending_d       = grant_valid && !ready;
    pending_index_d = pending_d ? sel_index : pending_index_q;
    pointer_d       = pointer_q;
    if (release_valid) begin
      pointer_d = (release_index == IDX_W'(SIZE - 1)) ? '0 : release_index + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer_q       <= '0;
      pending_q       <= 1'b0;
      pending_index_q <= '0;
    end else begin
      pointer_q       <= pointer_d;
      pending_q       <= pending_d;
      pending_index_q <= pending_index_d;
    end
  end

endmodule
